// File: rtl/cpu_pkg.sv
// Shared types and constants for the 2A03 interrupt/reset sequencer.
// Covers state encoding, default vector addresses and status-register bit positions.
package cpu_pkg;

   typedef enum logic [3:0] {
      RST_HOLD,
      RST_D1,
      RST_D2,
      RST_D3,
      IDLE,
      PUSH_PCH,
      PUSH_PCL,
      PUSH_P,
      VEC_LO,
      VEC_HI,
      LOAD
   } seq_state_t;

   localparam logic [15:0] NMI_VEC_DEF = 16'hFFFA;
   localparam logic [15:0] RST_VEC_DEF = 16'hFFFC;
   localparam logic [15:0] IRQ_VEC_DEF = 16'hFFFE;

   localparam int unsigned STATUS_B = 4;
   localparam int unsigned STATUS_U = 5;
   localparam int unsigned STATUS_I = 2;

   function automatic int unsigned src_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Status byte as stored on the stack by a hardware interrupt: B clear, bit 5 set.
   function automatic logic [7:0] push_status(input logic [7:0] p);
      logic [7:0] r;
      r           = p;
      r[STATUS_B] = 1'b0;
      r[STATUS_U] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/cpu_int_seq_if.sv
// CPU memory bus owned by the interrupt sequencer while it is busy.
// Read data is returned one cycle after the address is presented.
interface cpu_bus_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
);
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] Data_to_RAM;
   logic [DATA_W-1:0] Data_from_RAM;

   modport master (
      output write,
      output addr,
      output Data_to_RAM,
      input  Data_from_RAM
   );

   modport slave (
      input  write,
      input  addr,
      input  Data_to_RAM,
      output Data_from_RAM
   );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over active-high request lines.
module irq_prio_enc
   import cpu_pkg::*;
#(
   parameter  int unsigned N     = 2,
   localparam int unsigned IDX_W = src_width(N)
) (
   input  logic [N-1:0]     i_req,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   // Scan from the top down so the lowest asserted index is the last one written.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int unsigned i = N; i > 0; i--) begin
         if (i_req[i-1]) begin
            o_idx   = IDX_W'(i - 1);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cpu_int_seq.sv
// Reset/NMI/IRQ entry sequencer: stacks PC and P, fetches a vector and loads PC.
// Owns the CPU bus (busy=1) for every state except IDLE.
module cpu_int_seq
   import cpu_pkg::*;
#(
   parameter  int unsigned ADDR_W     = 16,
   parameter  int unsigned DATA_W     = 8,
   parameter  int unsigned N_IRQ      = 2,
   parameter  logic [7:0]  STACK_PAGE = 8'h01,
   parameter  logic [15:0] NMI_VEC    = NMI_VEC_DEF,
   parameter  logic [15:0] RST_VEC    = RST_VEC_DEF,
   parameter  logic [15:0] IRQ_VEC    = IRQ_VEC_DEF,
   localparam int unsigned SRC_W      = src_width(N_IRQ)
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             nmi_n,
   input  logic [N_IRQ-1:0] irq_n,
   input  logic             i_flag,
   input  logic             inst_boundary,
   input  logic [15:0]      pc_in,
   input  logic [7:0]       p_in,
   input  logic [7:0]       sp_in,
   cpu_bus_if.master        bus,
   output logic             busy,
   output logic [15:0]      pc_out,
   output logic             pc_load,
   output logic [7:0]       sp_out,
   output logic             sp_load,
   output logic             set_i,
   output logic [SRC_W-1:0] irq_src,
   output logic             done
);

   seq_state_t       r_state, w_state_nxt;
   logic [7:0]       r_sp, w_sp_cur;
   logic [15:0]      r_vec_base;
   logic [7:0]       r_vec_lo;
   logic [15:0]      r_pc;
   logic             r_nmi_hist, r_nmi_pend;
   logic [SRC_W-1:0] r_irq_src;

   logic             w_irq_valid;
   logic [SRC_W-1:0] w_irq_idx;
   logic             w_nmi_edge, w_take_nmi, w_take_irq, w_load;
   logic [15:0]      w_addr16, w_vec_full;
   logic [7:0]       w_byte;
   logic             w_write;

   irq_prio_enc #(.N(N_IRQ)) u_prio (
      .i_req   (~irq_n),
      .o_idx   (w_irq_idx),
      .o_valid (w_irq_valid)
   );

   // Pending NMI alone gates entry, so a fresh edge in the entry cycle is only queued.
   always_comb begin
      w_nmi_edge = r_nmi_hist & ~nmi_n;
      w_take_nmi = (r_state == IDLE) & inst_boundary & r_nmi_pend;
      w_take_irq = (r_state == IDLE) & inst_boundary & ~r_nmi_pend & w_irq_valid & ~i_flag;
      w_sp_cur   = ((r_state == RST_D1) || (r_state == PUSH_PCH)) ? sp_in : r_sp;
      w_vec_full = {bus.Data_from_RAM[7:0], r_vec_lo};
      w_load     = (r_state == LOAD);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RST_HOLD: w_state_nxt = RST_D1;
         RST_D1:   w_state_nxt = RST_D2;
         RST_D2:   w_state_nxt = RST_D3;
         RST_D3:   w_state_nxt = VEC_LO;
         IDLE:     if (w_take_nmi || w_take_irq) w_state_nxt = PUSH_PCH;
         PUSH_PCH: w_state_nxt = PUSH_PCL;
         PUSH_PCL: w_state_nxt = PUSH_P;
         PUSH_P:   w_state_nxt = VEC_LO;
         VEC_LO:   w_state_nxt = VEC_HI;
         VEC_HI:   w_state_nxt = LOAD;
         LOAD:     w_state_nxt = IDLE;
         default:  w_state_nxt = RST_HOLD;
      endcase
   end

   always_comb begin
      w_addr16 = '0;
      w_write  = 1'b0;
      w_byte   = '0;
      case (r_state)
         RST_D1, RST_D2, RST_D3: w_addr16 = {STACK_PAGE, w_sp_cur};
         PUSH_PCH: begin
            w_addr16 = {STACK_PAGE, w_sp_cur};
            w_write  = 1'b1;
            w_byte   = pc_in[15:8];
         end
         PUSH_PCL: begin
            w_addr16 = {STACK_PAGE, w_sp_cur};
            w_write  = 1'b1;
            w_byte   = pc_in[7:0];
         end
         PUSH_P: begin
            w_addr16 = {STACK_PAGE, w_sp_cur};
            w_write  = 1'b1;
            w_byte   = push_status(p_in);
         end
         VEC_LO:  w_addr16 = r_vec_base;
         VEC_HI:  w_addr16 = r_vec_base + 16'd1;
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state    <= RST_HOLD;
         r_sp       <= '0;
         r_vec_base <= RST_VEC;
         r_vec_lo   <= '0;
         r_pc       <= '0;
         r_nmi_hist <= 1'b1;
         r_nmi_pend <= 1'b0;
         r_irq_src  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_nmi_hist <= nmi_n;
         r_nmi_pend <= w_take_nmi ? 1'b0 : (r_nmi_pend | w_nmi_edge);
         if (w_take_nmi) begin
            r_vec_base <= NMI_VEC;
         end else if (w_take_irq) begin
            r_vec_base <= IRQ_VEC;
            r_irq_src  <= w_irq_idx;
         end else if (r_state == RST_HOLD) begin
            r_vec_base <= RST_VEC;
         end
         case (r_state)
            RST_D1, RST_D2, RST_D3,
            PUSH_PCH, PUSH_PCL, PUSH_P: r_sp     <= w_sp_cur - 8'd1;
            VEC_HI:                     r_vec_lo <= bus.Data_from_RAM[7:0];
            LOAD:                       r_pc     <= w_vec_full;
            default: ;
         endcase
      end
   end

   assign bus.write       = w_write;
   assign bus.addr        = ADDR_W'(w_addr16);
   assign bus.Data_to_RAM = DATA_W'(w_byte);
   assign busy            = (r_state != IDLE);
   assign pc_out          = w_load ? w_vec_full : r_pc;
   assign pc_load         = w_load;
   assign sp_out          = r_sp;
   assign sp_load         = w_load;
   assign set_i           = w_load;
   assign done            = w_load;
   assign irq_src         = r_irq_src;

endmodule

// File: tb/tb_cpu_int_seq.sv
// Self-checking bench for cpu_int_seq: vector table of entry scenarios plus
// hand-built sequences for NMI-during-IRQ and reset abort, checked cycle by cycle.
module tb_cpu_int_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        nmi_n;
   logic [1:0]  irq_n;
   logic        i_flag;
   logic        inst_boundary;
   logic [15:0] pc_in;
   logic [7:0]  p_in;
   logic [7:0]  sp_in;
   logic        busy, pc_load, sp_load, set_i, done;
   logic [15:0] pc_out;
   logic [7:0]  sp_out;
   logic [0:0]  irq_src;

   int n_checks = 0;
   int n_errors = 0;

   cpu_bus_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   cpu_int_seq #(
      .ADDR_W(16), .DATA_W(8), .N_IRQ(2), .STACK_PAGE(8'h01),
      .NMI_VEC(16'hFFFA), .RST_VEC(16'hFFFC), .IRQ_VEC(16'hFFFE)
   ) dut (
      .Clk(clk), .reset(reset), .nmi_n(nmi_n), .irq_n(irq_n), .i_flag(i_flag),
      .inst_boundary(inst_boundary), .pc_in(pc_in), .p_in(p_in), .sp_in(sp_in),
      .bus(bus), .busy(busy), .pc_out(pc_out), .pc_load(pc_load), .sp_out(sp_out),
      .sp_load(sp_load), .set_i(set_i), .irq_src(irq_src), .done(done)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (bus.write) mem[bus.addr] <= bus.Data_to_RAM;
      bus.Data_from_RAM <= mem[bus.addr];
   end

   typedef struct {
      bit          busy, wr, ca, ld, cp, cs;
      logic [15:0] a;
      logic [7:0]  d;
      logic [15:0] pc;
      logic [7:0]  sp;
      logic        src;
   } cyc_t;

   typedef struct {
      bit          nmi;
      logic [1:0]  irqn;
      bit          iflag;
      logic [15:0] pc;
      logic [7:0]  p, sp;
      bit          taken;
      logic [15:0] vec, epc;
      logic [7:0]  esp;
      logic        esrc;
   } rec_t;

   cyc_t exp_q[$];
   rec_t tbl[8];

   function automatic cyc_t mk(bit busy_e, bit wr, bit ca, logic [15:0] a, logic [7:0] d,
                               bit ld, bit cp, logic [15:0] pc, logic [7:0] sp,
                               bit cs, logic src);
      cyc_t c;
      c.busy = busy_e; c.wr = wr; c.ca = ca; c.a = a; c.d = d;
      c.ld = ld; c.cp = cp; c.pc = pc; c.sp = sp; c.cs = cs; c.src = src;
      return c;
   endfunction

   function automatic cyc_t idle_c();
      return mk(0, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0, 1'b0);
   endfunction

   function automatic cyc_t hold_c();
      return mk(1, 0, 1, 16'h0000, 8'h0, 0, 1, 16'h0000, 8'h0, 1, 1'b0);
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push_int(input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp,
                           input logic [15:0] vec, input logic [15:0] epc, input logic [7:0] esp,
                           input bit cs, input logic src);
      logic [7:0] s0, s1, s2, pp;
      s0 = sp; s1 = s0 - 8'd1; s2 = s1 - 8'd1;
      pp = p;
      pp[4] = 1'b0;
      pp[5] = 1'b1;
      exp_q.push_back(mk(1, 1, 1, {8'h01, s0}, pc[15:8], 0, 0, 16'h0, 8'h0, 0, 1'b0));
      exp_q.push_back(mk(1, 1, 1, {8'h01, s1}, pc[7:0],  0, 0, 16'h0, 8'h0, 0, 1'b0));
      exp_q.push_back(mk(1, 1, 1, {8'h01, s2}, pp,       0, 0, 16'h0, 8'h0, 0, 1'b0));
      exp_q.push_back(mk(1, 0, 1, vec,          8'h0,    0, 0, 16'h0, 8'h0, 0, 1'b0));
      exp_q.push_back(mk(1, 0, 1, vec + 16'd1,  8'h0,    0, 0, 16'h0, 8'h0, 0, 1'b0));
      exp_q.push_back(mk(1, 0, 0, 16'h0,        8'h0,    1, 1, epc,   esp,  cs, src));
      exp_q.push_back(idle_c());
   endtask

   task automatic push_rst(input logic [7:0] sp, input logic [15:0] epc, input logic [7:0] esp);
      logic [7:0] s0, s1, s2;
      s0 = sp; s1 = s0 - 8'd1; s2 = s1 - 8'd1;
      exp_q.push_back(mk(1, 0, 1, {8'h01, s0}, 8'h0, 0, 0, 16'h0, 8'h0, 0, 1'b0));
      exp_q.push_back(mk(1, 0, 1, {8'h01, s1}, 8'h0, 0, 0, 16'h0, 8'h0, 0, 1'b0));
      exp_q.push_back(mk(1, 0, 1, {8'h01, s2}, 8'h0, 0, 0, 16'h0, 8'h0, 0, 1'b0));
      exp_q.push_back(mk(1, 0, 1, 16'hFFFC,    8'h0, 0, 0, 16'h0, 8'h0, 0, 1'b0));
      exp_q.push_back(mk(1, 0, 1, 16'hFFFD,    8'h0, 0, 0, 16'h0, 8'h0, 0, 1'b0));
      exp_q.push_back(mk(1, 0, 0, 16'h0,       8'h0, 1, 1, epc,   esp,  0, 1'b0));
      exp_q.push_back(idle_c());
   endtask

   // Pops one expectation per cycle; hooks change inputs right after a given cycle's check.
   task automatic run_q(input int rel_at, input int nmi_at, input int rst_at);
      int   idx;
      cyc_t e;
      idx = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         chk("busy",    16'(busy),      16'(e.busy));
         chk("write",   16'(bus.write), 16'(e.wr));
         if (e.ca) chk("addr", bus.addr, e.a);
         if (e.wr) chk("wdata", 16'(bus.Data_to_RAM), 16'(e.d));
         chk("pc_load", 16'(pc_load), 16'(e.ld));
         chk("sp_load", 16'(sp_load), 16'(e.ld));
         chk("set_i",   16'(set_i),   16'(e.ld));
         chk("done",    16'(done),    16'(e.ld));
         if (e.cp) chk("pc_out",  pc_out,        e.pc);
         if (e.ld) chk("sp_out",  16'(sp_out),   16'(e.sp));
         if (e.cs) chk("irq_src", 16'(irq_src),  16'(e.src));
         if (idx == rel_at) begin irq_n = 2'b11; inst_boundary = 1'b0; end
         if (idx == nmi_at) nmi_n = 1'b0;
         if (idx == rst_at) reset = 1'b1;
         idx++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rec_t r;
      tbl[0] = '{1, 2'b11, 0, 16'hC123, 8'h30, 8'hFF, 1, 16'hFFFA, 16'h5678, 8'hFC, 1'b0};
      tbl[1] = '{0, 2'b00, 0, 16'h8000, 8'h04, 8'hFD, 1, 16'hFFFE, 16'h9ABC, 8'hFA, 1'b0};
      tbl[2] = '{0, 2'b00, 1, 16'h8000, 8'h04, 8'hFD, 0, 16'h0000, 16'h0000, 8'h00, 1'b0};
      tbl[3] = '{0, 2'b01, 0, 16'h1357, 8'hFF, 8'h01, 1, 16'hFFFE, 16'h9ABC, 8'hFE, 1'b1};
      tbl[4] = '{0, 2'b10, 0, 16'h2468, 8'h00, 8'h00, 1, 16'hFFFE, 16'h9ABC, 8'hFD, 1'b0};
      tbl[5] = '{1, 2'b00, 0, 16'h4000, 8'hC3, 8'h80, 1, 16'hFFFA, 16'h5678, 8'h7D, 1'b0};
      tbl[6] = '{1, 2'b11, 1, 16'hA5A5, 8'h10, 8'h10, 1, 16'hFFFA, 16'h5678, 8'h0D, 1'b0};
      tbl[7] = '{0, 2'b01, 1, 16'h0000, 8'h00, 8'h20, 0, 16'h0000, 16'h0000, 8'h00, 1'b0};

      mem[16'hFFFA] = 8'h78; mem[16'hFFFB] = 8'h56;
      mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
      mem[16'hFFFE] = 8'hBC; mem[16'hFFFF] = 8'h9A;

      reset = 1'b1; nmi_n = 1'b1; irq_n = 2'b11; i_flag = 1'b0; inst_boundary = 1'b0;
      pc_in = 16'h0; p_in = 8'h0; sp_in = 8'hFD;
      repeat (2) @(posedge clk);
      exp_q.push_back(hold_c());
      exp_q.push_back(hold_c());
      run_q(-1, -1, -1);
      reset = 1'b0;
      push_rst(8'hFD, 16'h1234, 8'hFA);
      run_q(-1, -1, -1);

      for (int i = 0; i < 8; i++) begin
         r = tbl[i];
         nmi_n = 1'b1; irq_n = 2'b11; inst_boundary = 1'b0; i_flag = r.iflag;
         pc_in = r.pc; p_in = r.p; sp_in = r.sp;
         exp_q.push_back(idle_c());
         run_q(-1, -1, -1);
         if (r.nmi) begin
            nmi_n = 1'b0; irq_n = r.irqn;
            exp_q.push_back(idle_c());
            run_q(-1, -1, -1);
         end
         inst_boundary = 1'b1; irq_n = r.irqn;
         if (r.taken) begin
            push_int(r.pc, r.p, r.sp, r.vec, r.epc, r.esp, !r.nmi, r.esrc);
            run_q(0, -1, -1);
         end else begin
            repeat (3) exp_q.push_back(idle_c());
            run_q(2, -1, -1);
         end
      end

      // NMI edge while an IRQ is stacking PCL: IRQ finishes, NMI follows at next boundary.
      nmi_n = 1'b1; irq_n = 2'b11; inst_boundary = 1'b0; i_flag = 1'b0;
      pc_in = 16'h3000; p_in = 8'h00; sp_in = 8'hF0;
      exp_q.push_back(idle_c());
      run_q(-1, -1, -1);
      inst_boundary = 1'b1; irq_n = 2'b10;
      push_int(16'h3000, 8'h00, 8'hF0, 16'hFFFE, 16'h9ABC, 8'hED, 1, 1'b0);
      run_q(0, 1, -1);
      inst_boundary = 1'b1; sp_in = 8'hED;
      push_int(16'h3000, 8'h00, 8'hED, 16'hFFFA, 16'h5678, 8'hEA, 0, 1'b0);
      run_q(0, -1, -1);
      inst_boundary = 1'b1;
      repeat (3) exp_q.push_back(idle_c());
      run_q(-1, -1, -1);
      inst_boundary = 1'b0; nmi_n = 1'b1;

      // Reset landing in VEC_HI aborts the entry; full reset sequence follows release.
      exp_q.push_back(idle_c());
      run_q(-1, -1, -1);
      inst_boundary = 1'b1; irq_n = 2'b00; pc_in = 16'h1111; sp_in = 8'h50;
      push_int(16'h1111, 8'h00, 8'h50, 16'hFFFE, 16'h9ABC, 8'h4D, 0, 1'b0);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      run_q(0, -1, 4);
      exp_q.push_back(hold_c());
      exp_q.push_back(hold_c());
      run_q(-1, -1, -1);
      reset = 1'b0; sp_in = 8'hFD;
      push_rst(8'hFD, 16'h1234, 8'hFA);
      run_q(-1, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
